// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life tile and its frame receiver.
// Both ends decode the 2-bit status code from this one enum.
package gol_pkg;

    localparam int N     = 25;
    localparam int n     = 5;
    localparam int GEN_W = 8;
    localparam int POP_W = 5;

    typedef enum logic [1:0] {
        ST_INPUT  = 2'b00,
        ST_UPDATE = 2'b01,
        ST_OUTPUT = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DRAIN   = 2'b10
    } rx_state_e;

endpackage

// File: rtl/gol_popcount.sv
// Combinational live-cell count of an N-cell board.
// Shared with the neighbour adders of the upstream tile.
module gol_popcount
    import gol_pkg::*;
(
    input  logic [N-1:0]     cells,
    output logic [POP_W-1:0] count
);

    // Ripple sum of every cell bit; 25 fits in 5 bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + POP_W'(cells[i]);
        end
    end

endmodule

// File: rtl/gol_frame_receiver.sv
// Reassembles 25-bit serial boards from the tile's OUTPUT phase,
// latches the last complete board and reports its status.
module gol_frame_receiver
    import gol_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       status,
    input  logic             serial_in,
    input  logic [2:0]       row_sel,
    output logic [n-1:0]     row_data,
    output logic             frame_valid,
    output logic [GEN_W-1:0] generation,
    output logic [POP_W-1:0] population,
    output logic             still_life,
    output logic             extinct,
    output logic             frame_err
);

    rx_state_e        state;
    rx_state_e        state_next;
    logic [N-1:0]     buffer;
    logic [N-1:0]     next_buf;
    logic [N-1:0]     board;
    logic [N-1:0]     prev;
    logic [4:0]       idx;
    logic             has_prev;
    logic             pair_valid;
    logic [POP_W-1:0] pop_next;

    logic             is_output;
    logic             is_input;
    logic             sample;
    logic             commit;
    logic             abort;
    logic             seed;

    assign is_output = (status == ST_OUTPUT);
    assign is_input  = (status == ST_INPUT);

    // Buffer with the current serial bit merged in at the bit index;
    // idx is 0 whenever the FSM sits in IDLE.
    always_comb begin
        next_buf      = buffer;
        next_buf[idx] = serial_in;
    end

    gol_popcount u_popcount (
        .cells (next_buf),
        .count (pop_next)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        seed       = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_output) begin
                    sample     = 1'b1;
                    state_next = CAPTURE;
                end else if (is_input) begin
                    seed = 1'b1;
                end
            end
            CAPTURE: begin
                if (is_output) begin
                    sample = 1'b1;
                    if (idx == 5'(N - 1)) begin
                        commit     = 1'b1;
                        state_next = DRAIN;
                    end
                end else begin
                    abort      = 1'b1;
                    seed       = is_input;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (!is_output) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture buffer, latched board and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            buffer      <= '0;
            board       <= '0;
            prev        <= '0;
            idx         <= '0;
            has_prev    <= 1'b0;
            pair_valid  <= 1'b0;
            frame_valid <= 1'b0;
            generation  <= '0;
            population  <= '0;
            extinct     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (sample) begin
                buffer <= next_buf;
                idx    <= idx + 5'd1;
            end
            if (commit) begin
                idx        <= '0;
                prev       <= board;
                board      <= next_buf;
                population <= pop_next;
                pair_valid <= has_prev;
                extinct    <= (pop_next == '0);
                has_prev   <= 1'b1;
                generation <= generation + GEN_W'(1);
            end
            if (abort) begin
                idx       <= '0;
                buffer    <= '0;
                frame_err <= 1'b1;
            end
            if (seed) begin
                generation <= '0;
                has_prev   <= 1'b0;
                pair_valid <= 1'b0;
                extinct    <= 1'b0;
            end
        end
    end

    // A board is a still life when it matches the one latched before it,
    // provided that earlier board belongs to the same seed.
    always_comb begin
        still_life = pair_valid && (board == prev);
    end

    // Row readback; rows past the board read as empty.
    always_comb begin
        row_data = '0;
        case (row_sel)
            3'd0:    row_data = board[4:0];
            3'd1:    row_data = board[9:5];
            3'd2:    row_data = board[14:10];
            3'd3:    row_data = board[19:15];
            3'd4:    row_data = board[24:20];
            default: row_data = '0;
        endcase
    end

endmodule

// File: tb/tb_gol_frame_receiver.sv
// Directed bench for gol_frame_receiver with a frame scoreboard
// checked whenever the receiver pulses frame_valid.
module tb_gol_frame_receiver;
    import gol_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       status;
    logic             serial_in;
    logic [2:0]       row_sel;
    logic [n-1:0]     row_data;
    logic             frame_valid;
    logic [GEN_W-1:0] generation;
    logic [POP_W-1:0] population;
    logic             still_life;
    logic             extinct;
    logic             frame_err;

    gol_frame_receiver dut (
        .clock       (clock),
        .reset       (reset),
        .status      (status),
        .serial_in   (serial_in),
        .row_sel     (row_sel),
        .row_data    (row_data),
        .frame_valid (frame_valid),
        .generation  (generation),
        .population  (population),
        .still_life  (still_life),
        .extinct     (extinct),
        .frame_err   (frame_err)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic [4:0] pop;
        logic [7:0] gen;
        logic       still;
        logic       ext;
    } exp_t;

    exp_t q[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [24:0] m_board;
    logic        m_has_prev;
    logic [7:0]  m_gen;
    logic [4:0]  m_pop;
    logic        m_still;
    logic        m_ext;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_board    = '0;
        m_has_prev = 1'b0;
        m_gen      = '0;
        m_pop      = '0;
        m_still    = 1'b0;
        m_ext      = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_seed();
        m_gen      = '0;
        m_has_prev = 1'b0;
        m_still    = 1'b0;
        m_ext      = 1'b0;
    endtask

    task automatic step(input logic [1:0] st, input logic b);
        status    = st;
        serial_in = b;
        @(posedge clock);
        #1;
    endtask

    // Drive len OUTPUT cycles then one UPDATE cycle; full frames push
    // their expected status onto the scoreboard.
    task automatic send(input logic [24:0] cells, input int len);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            if (k < 25) step(ST_OUTPUT, cells[k]);
            else        step(ST_OUTPUT, 1'($urandom));
            if (k == 24) begin
                m_pop      = 5'($countones(cells));
                m_still    = m_has_prev && (cells == m_board);
                m_ext      = (m_pop == 0);
                m_board    = cells;
                m_has_prev = 1'b1;
                m_gen      = m_gen + 8'd1;
                e.pop      = m_pop;
                e.gen      = m_gen;
                e.still    = m_still;
                e.ext      = m_ext;
                q.push_back(e);
            end
        end
        step(ST_UPDATE, 1'b0);
        if (len < 25) m_err = 1'b1;
        chk("frame_latency_pending", q.size(), 0);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_gen"},   generation, m_gen);
        chk({tag, "_pop"},   population, m_pop);
        chk({tag, "_still"}, still_life, m_still);
        chk({tag, "_ext"},   extinct,    m_ext);
        chk({tag, "_err"},   frame_err,  m_err);
    endtask

    task automatic check_rows(input string tag);
        logic [4:0] er;
        for (int r = 0; r < 8; r++) begin
            row_sel = 3'(r);
            #1;
            er = (r < 5) ? m_board[r*5 +: 5] : 5'd0;
            chk($sformatf("%s_row%0d", tag, r), row_data, er);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(ST_UPDATE, 1'b0);
        step(ST_UPDATE, 1'b0);
        reset = 1'b0;
        model_reset();
    endtask

    // Scoreboard pop on every frame_valid pulse.
    always @(negedge clock) begin
        if (frame_valid === 1'b1) begin
            chk("frame_valid_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("fv_pop",   population, e.pop);
                chk("fv_gen",   generation, e.gen);
                chk("fv_still", still_life, e.still);
                chk("fv_ext",   extinct,    e.ext);
            end
        end
    end

    localparam logic [24:0] H_BLINK = 25'h0003800;
    localparam logic [24:0] V_BLINK = 25'h0021080;
    localparam logic [24:0] BLOCK   = 25'h0000063;

    initial begin
        logic [24:0] c;
        status    = ST_UPDATE;
        serial_in = 1'b0;
        row_sel   = '0;
        reset     = 1'b0;
        model_reset();

        do_reset();
        check_outs("reset");
        chk("reset_fv", frame_valid, 0);
        check_rows("reset");

        send(H_BLINK, 25);
        check_outs("blink_h");
        row_sel = 3'd2;
        #1;
        chk("blink_row2", row_data, 5'b01110);
        check_rows("blink_h");

        send(V_BLINK, 25);
        check_outs("blink_v");
        check_rows("blink_v");
        send(H_BLINK, 25);
        check_outs("blink_h2");
        chk("blink_gen3", generation, 8'd3);

        send(BLOCK, 25);
        send(BLOCK, 25);
        check_outs("block2");
        chk("block_still", still_life, 1'b1);
        chk("block_pop", population, 5'd4);

        send(H_BLINK, 10);
        check_outs("abort");
        chk("abort_err", frame_err, 1'b1);
        check_rows("abort");
        send(V_BLINK, 25);
        check_outs("after_abort");
        check_rows("after_abort");

        send(25'd0, 25);
        check_outs("zero");
        chk("zero_extinct", extinct, 1'b1);
        send(25'h1ABCDEF, 30);
        check_outs("long");
        check_rows("long");

        step(ST_INPUT, 1'b0);
        model_seed();
        check_outs("seed");
        check_rows("seed");
        send(m_board, 25);
        check_outs("seed_same");
        chk("seed_still0", still_life, 1'b0);

        step(ST_INPUT, 1'b0);
        model_seed();
        for (int i = 0; i < 255; i++) begin
            if (i % 3 == 2) c = m_board;
            else            c = 25'($urandom);
            send(c, 25);
        end
        check_outs("wrap255");
        chk("gen255", generation, 8'd255);
        send(BLOCK, 25);
        check_outs("wrap0");
        chk("gen0", generation, 8'd0);

        for (int k = 0; k < 12; k++) step(ST_OUTPUT, H_BLINK[k]);
        do_reset();
        check_outs("midreset");
        check_rows("midreset");
        send(H_BLINK, 25);
        check_outs("post_reset");
        chk("post_reset_gen1", generation, 8'd1);
        check_rows("post_reset");

        step(ST_UPDATE, 1'b0);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
